// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared state encodings and counter sizing for the bus synchronizer
package sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } sync_state_t;

  // Counter holds at most max(hold,gap)-1; keep one bit even when both phases are 1 cycle.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bus_sync_tx.sv
// rtl/bus_sync_tx.sv - launches words as a stable bus plus a held level enable for a destination synchronizer
module bus_sync_tx
  import sync_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic [BUS_WIDTH-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [BUS_WIDTH-1:0] o_unsync_bus,
  output logic                 o_bus_enable,
  output logic                 o_busy
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  sync_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [BUS_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [BUS_WIDTH-1:0] bus_q, bus_d;
  logic                 en_q, en_d;
  logic                 accept;

  assign accept = i_valid & ~pend_valid_q;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      bus_q        <= '0;
      en_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      bus_q        <= bus_d;
      en_q         <= en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    bus_d        = bus_q;
    en_d         = en_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bus_d   = i_data;
          en_d    = 1'b1;
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          pend_data_d  = i_data;
          pend_valid_d = 1'b1;
        end
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          cnt_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (accept) begin
            pend_data_d  = i_data;
            pend_valid_d = 1'b1;
          end
        end else if (pend_valid_q) begin
          // Queued word goes out exactly GAP_CYCLES after the previous enable fell.
          bus_d        = pend_data_q;
          en_d         = 1'b1;
          cnt_d        = HOLD_LOAD;
          pend_valid_d = 1'b0;
          state_d      = ST_HOLD;
        end else if (accept) begin
          bus_d   = i_data;
          en_d    = 1'b1;
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_unsync_bus = bus_q;
  assign o_bus_enable = en_q;
  assign o_ready      = ~pend_valid_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_sync_tx.sv
// tb/tb_bus_sync_tx.sv - directed vector bench for bus_sync_tx with a destination synchronizer model
module tb_bus_sync_tx;

  logic       i_CLK = 1'b0;
  logic       i_RST = 1'b0;
  logic [3:0] i_data = 4'h0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [3:0] o_unsync_bus;
  logic       o_bus_enable;
  logic       o_busy;

  int checks = 0;
  int failures = 0;

  bus_sync_tx #(.BUS_WIDTH(4), .HOLD_CYCLES(3), .GAP_CYCLES(2)) dut (
    .i_CLK       (i_CLK),
    .i_RST       (i_RST),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_unsync_bus(o_unsync_bus),
    .o_bus_enable(o_bus_enable),
    .o_busy      (o_busy)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic       valid;
    logic [3:0] data;
    logic       exp_ready;
    logic [3:0] exp_bus;
    logic       exp_en;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  // Source-side monitor: words launched, enable-high length per word, low run between words.
  logic       mon_en = 1'b0;
  logic       mon_prev_en = 1'b0;
  logic [3:0] mon_words[$];
  int         mon_highs[$];
  int         mon_lows[$];
  int         low_run = 0;

  always @(negedge i_CLK) begin
    if (mon_en) begin
      if (o_bus_enable && !mon_prev_en) begin
        if (mon_words.size() > 0) mon_lows.push_back(low_run);
        mon_words.push_back(o_unsync_bus);
        mon_highs.push_back(1);
        low_run = 0;
      end else if (o_bus_enable) begin
        mon_highs[mon_highs.size()-1] = mon_highs[mon_highs.size()-1] + 1;
      end else if (o_busy && mon_words.size() > 0) begin
        low_run = low_run + 1;
      end
      mon_prev_en = o_bus_enable;
    end
  end

  // Destination: two-flop enable synchronizer, bus captured on synchronized rising edge.
  logic       s1, s2, s3;
  logic [3:0] dst_words[$];

  always @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= o_bus_enable;
      s2 <= s1;
      s3 <= s2;
      if (s2 && !s3) dst_words.push_back(o_unsync_bus);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [3:0] d, input logic r,
                     input logic [3:0] b, input logic e, input logic y);
    vec_t t;
    t.valid = v; t.data = d; t.exp_ready = r; t.exp_bus = b; t.exp_en = e; t.exp_busy = y;
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(o_busy), 32'(0));
  endtask

  task automatic clear_mon();
    mon_words.delete();
    mon_highs.delete();
    mon_lows.delete();
    dst_words.delete();
    low_run = 0;
    mon_prev_en = o_bus_enable;
  endtask

  initial begin
    int acc_cyc[3];
    logic [3:0] words[3];
    int idx;
    int cyc;
    logic acc;

    // Single word 1011: three enable-high, two low, then idle (bus retained)
    add(1, 4'hB, 1, 4'hB, 1, 1);
    add(0, 4'h0, 1, 4'hB, 1, 1);
    add(0, 4'h0, 1, 4'hB, 1, 1);
    add(0, 4'h0, 1, 4'hB, 0, 1);
    add(0, 4'h0, 1, 4'hB, 0, 1);
    add(0, 4'h0, 1, 4'hB, 0, 0);
    add(0, 4'h0, 1, 4'hB, 0, 0);
    // Back-to-back A then 5 queued during HOLD
    add(1, 4'hA, 1, 4'hA, 1, 1);
    add(1, 4'h5, 0, 4'hA, 1, 1);
    add(0, 4'h0, 0, 4'hA, 1, 1);
    add(0, 4'h0, 0, 4'hA, 0, 1);
    add(0, 4'h0, 0, 4'hA, 0, 1);
    add(0, 4'h0, 1, 4'h5, 1, 1);
    add(0, 4'h0, 1, 4'h5, 1, 1);
    add(0, 4'h0, 1, 4'h5, 1, 1);
    add(0, 4'h0, 1, 4'h5, 0, 1);
    add(0, 4'h0, 1, 4'h5, 0, 1);
    add(0, 4'h0, 1, 4'h5, 0, 0);
    // Late arrival of 3 on the last GAP cycle launches directly
    add(1, 4'h9, 1, 4'h9, 1, 1);
    add(0, 4'h0, 1, 4'h9, 1, 1);
    add(0, 4'h0, 1, 4'h9, 1, 1);
    add(0, 4'h0, 1, 4'h9, 0, 1);
    add(0, 4'h0, 1, 4'h9, 0, 1);
    add(1, 4'h3, 1, 4'h3, 1, 1);
    add(0, 4'h0, 1, 4'h3, 1, 1);
    add(0, 4'h0, 1, 4'h3, 1, 1);
    add(0, 4'h0, 1, 4'h3, 0, 1);
    add(0, 4'h0, 1, 4'h3, 0, 1);
    add(0, 4'h0, 1, 4'h3, 0, 0);

    // Reset state, with valid asserted to show nothing is taken during reset
    i_valid = 1'b1;
    i_data  = 4'hF;
    repeat (3) step();
    chk("rst_ready", 32'(o_ready), 32'(1));
    chk("rst_bus", 32'(o_unsync_bus), 32'(0));
    chk("rst_en", 32'(o_bus_enable), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    i_valid = 1'b0;
    i_RST = 1'b1;
    repeat (2) step();
    chk("idle_bus", 32'(o_unsync_bus), 32'(0));

    for (int i = 0; i < vecs.size(); i++) begin
      i_valid = vecs[i].valid;
      i_data  = vecs[i].data;
      step();
      chk($sformatf("vec%0d_ready", i), 32'(o_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_bus", i), 32'(o_unsync_bus), 32'(vecs[i].exp_bus));
      chk($sformatf("vec%0d_en", i), 32'(o_bus_enable), 32'(vecs[i].exp_en));
      chk($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(vecs[i].exp_busy));
    end
    i_valid = 1'b0;

    // Stall: three words offered continuously, third waits for pending to drain
    clear_mon();
    mon_en = 1'b1;
    words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3;
    acc_cyc[0] = -1; acc_cyc[1] = -1; acc_cyc[2] = -1;
    idx = 0;
    cyc = 0;
    i_valid = 1'b1;
    i_data  = words[0];
    while (idx < 3 && cyc < 100) begin
      acc = o_ready;
      step();
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) i_data = words[idx];
        else i_valid = 1'b0;
      end
      cyc++;
    end
    i_valid = 1'b0;
    chk("stall_accepts", 32'(idx), 32'(3));
    chk("stall_acc2", 32'(acc_cyc[1] - acc_cyc[0]), 32'(1));
    chk("stall_acc3", 32'(acc_cyc[2] - acc_cyc[0]), 32'(6));
    wait_idle(60);
    repeat (5) step();
    chk("stall_nwords", 32'(mon_words.size()), 32'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < mon_words.size()) begin
        chk($sformatf("stall_word%0d", i), 32'(mon_words[i]), 32'(words[i]));
        chk($sformatf("stall_high%0d", i), 32'(mon_highs[i]), 32'(3));
      end
    end
    chk("stall_nlows", 32'(mon_lows.size()), 32'(2));
    foreach (mon_lows[i]) chk($sformatf("stall_low%0d", i), 32'(mon_lows[i]), 32'(2));
    chk("loop_npulses", 32'(dst_words.size()), 32'(3));
    foreach (dst_words[i])
      if (i < 3) chk($sformatf("loop_word%0d", i), 32'(dst_words[i]), 32'(words[i]));

    // Reset mid-HOLD with 6 pending
    i_valid = 1'b1; i_data = 4'h2; step();
    i_data = 4'h6; step();
    i_valid = 1'b0;
    chk("pre_rst_ready", 32'(o_ready), 32'(0));
    chk("pre_rst_en", 32'(o_bus_enable), 32'(1));
    #2 i_RST = 1'b0;
    #1;
    chk("midrst_en", 32'(o_bus_enable), 32'(0));
    chk("midrst_bus", 32'(o_unsync_bus), 32'(0));
    chk("midrst_ready", 32'(o_ready), 32'(1));
    chk("midrst_busy", 32'(o_busy), 32'(0));
    step();
    i_RST = 1'b1;
    clear_mon();
    repeat (10) step();
    chk("post_rst_nwords", 32'(mon_words.size()), 32'(0));
    chk("post_rst_bus", 32'(o_unsync_bus), 32'(0));
    i_valid = 1'b1; i_data = 4'hC; step();
    i_valid = 1'b0;
    chk("relaunch_bus", 32'(o_unsync_bus), 32'(4'hC));
    chk("relaunch_en", 32'(o_bus_enable), 32'(1));
    wait_idle(20);
    repeat (5) step();
    chk("relaunch_nwords", 32'(mon_words.size()), 32'(1));
    if (mon_words.size() > 0) chk("relaunch_word", 32'(mon_words[0]), 32'(4'hC));
    chk("relaunch_npulses", 32'(dst_words.size()), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_sync_tx.md
BUS_SYNC_TX -- requirements
Module: bus_sync_tx

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, meaning the data bus width in bits.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 4, meaning the number of cycles o_bus_enable stays high per word (legal range >=1).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, meaning the number of low-enable cycles after each HOLD with data still stable (legal range >=1).
REQ-004 The block SHALL have port i_CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_RST  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_data  input  BUS_WIDTH  word to launch.
REQ-007 The block SHALL have port i_valid  input  1  i_data is valid.
REQ-008 The block SHALL have port o_ready  output  1  block can accept a word this cycle.
REQ-009 The block SHALL have port o_unsync_bus  output  BUS_WIDTH  registered bus toward the destination synchronizer.
REQ-010 The block SHALL have port o_bus_enable  output  1  registered level qualifier toward the destination synchronizer.
REQ-011 The block SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-012 Acceptance SHALL occur at a rising edge where i_valid and o_ready are both 1; o_ready SHALL equal NOT pending_valid.
REQ-013 FSM SHALL have states IDLE, HOLD and GAP.
REQ-014 In IDLE, an accepted word SHALL load o_unsync_bus directly; o_bus_enable SHALL go to 1 at that same edge; the next state SHALL be HOLD, and the down-counter SHALL be loaded with HOLD_CYCLES-1.
REQ-015 In HOLD or GAP, an accepted word SHALL be stored in the one-deep pending register, and pending_valid SHALL be set.
REQ-016 HOLD SHALL keep o_bus_enable at 1 for exactly HOLD_CYCLES cycles; when the counter reaches 0, the next state SHALL be GAP, o_bus_enable SHALL go to 0, and the counter SHALL load GAP_CYCLES-1.
REQ-017 o_unsync_bus SHALL remain unchanged from launch until the end of GAP.
REQ-018 At the last GAP cycle: if pending_valid, the block SHALL launch the pending word (bus load, enable 1, HOLD) and clear pending_valid.
REQ-019 At the last GAP cycle with pending empty and an accept in the same cycle, the block SHALL launch the input word directly, with no IDLE cycle.
REQ-020 At the last GAP cycle with no pending word and no accept, the next state SHALL be IDLE.
REQ-021 Between consecutive words, o_bus_enable SHALL be low for exactly GAP_CYCLES cycles, so the destination produces one enable pulse per word.
REQ-022 In IDLE, o_unsync_bus SHALL retain the last launched word.
REQ-023 A pending word SHALL never be overwritten, because o_ready=0 while pending_valid=1.

Reset
REQ-024 While i_RST=0: state=IDLE, counter=0, pending_valid=0, pending data=0, o_unsync_bus=0, o_bus_enable=0, o_busy=0, o_ready=1.
REQ-025 An assertion of i_RST mid-HOLD or mid-GAP SHALL immediately drop o_bus_enable and discard any pending word; after reset is released, operation SHALL resume from IDLE.

Structure
REQ-026 State encodings and the counter-width constant (clog2 of max(HOLD_CYCLES,GAP_CYCLES)) SHALL reside in shared package sync_pkg.
REQ-027 The block SHALL be flat, containing the FSM, counter and pending register; no sub-module is required.
REQ-028 All outputs SHALL be driven from flops except o_ready and o_busy, which are direct decodes of flops.

Verification (BUS_WIDTH=4, HOLD_CYCLES=3, GAP_CYCLES=2)
REQ-029 Single word: accept 4'b1011 at edge t -> bus=1011 from t; enable=1 after edges t, t+1, t+2; enable=0 after t+3 and t+4; busy=0 after t+5.
REQ-030 Back-to-back: send 4'hA, then 4'h5 during HOLD -> ready=0 until t+4; 4'h5 is launched at t+5 after exactly 2 low-enable cycles; 4'hA is held stable through t+4.
REQ-031 Late arrival: send 4'h3 with i_valid asserted only on the last GAP cycle and pending empty -> launched at that edge; busy never drops.
REQ-032 Stall: present 3 words continuously -> the third is accepted only once the second leaves pending; all 3 appear in order, with 3 enable-high cycles each.
REQ-033 Reset mid-HOLD with 4'h6 pending -> enable=0 and bus=0 immediately; 4'h6 is never launched; the next accept after release launches normally.
REQ-034 Loopback into the destination synchronizer (NUM_STAGES=2, same clock) -> exactly one enable pulse per word, and the synchronized bus matches each sent word.
